// File: rtl/ps2_pkg.sv
// Shared PS/2 frame constants and byte type for the receiver slice.
package ps2_pkg;
   localparam logic [3:0] PS2_FRAME_BITS = 4'd11;
   localparam logic [3:0] PS2_START      = 4'd0;
   localparam logic [3:0] PS2_PARITY     = 4'd9;
   localparam logic [3:0] PS2_STOP       = PS2_FRAME_BITS - 4'd1;

   typedef logic [7:0] ps2_byte_t;
endpackage

// File: rtl/ps2_clk_filter.sv
// Two-flop synchroniser for both PS/2 pins, FILTER_LEN-sample deglitch on the
// clock pin, and a one-cycle strobe on each falling edge of the filtered clock.
module ps2_clk_filter #(
   parameter int FILTER_LEN = 4
) (
   input  logic clk,
   input  logic clr,
   input  logic ps2_clk,
   input  logic ps2_data,
   output logic sample,
   output logic data_sync
);
   localparam int CW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;

   logic [1:0]    clk_sync;
   logic [1:0]    dat_sync;
   logic          filt;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (clr) begin
         clk_sync <= 2'b11;
         dat_sync <= 2'b11;
         filt     <= 1'b1;
         cnt      <= '0;
         sample   <= 1'b0;
      end else begin
         clk_sync <= {clk_sync[0], ps2_clk};
         dat_sync <= {dat_sync[0], ps2_data};
         sample   <= 1'b0;
         // cnt tracks how long the synchronised pin has disagreed with filt
         if (clk_sync[1] == filt) begin
            cnt <= '0;
         end else if (cnt == CW'(FILTER_LEN - 1)) begin
            filt   <= clk_sync[1];
            cnt    <= '0;
            sample <= filt;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   assign data_sync = dat_sync[1];
endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: frame deserialiser, byte FIFO, sticky flags.
// Define PS2_RX_TIMEOUT_EN to add the mid-frame idle timeout resync.
module ps2_rx_fifo
   import ps2_pkg::*;
#(
   parameter int DEPTH_LOG2     = 3,
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 10000
) (
   input  logic                clk,
   input  logic                clr,
   input  logic                ps2_clk,
   input  logic                ps2_data,
   input  logic                rdn,
   output logic [7:0]          data,
   output logic                ready,
   output logic                overflow,
   output logic                parity_err,
   output logic                frame_err,
   output logic [DEPTH_LOG2:0] level
);
   localparam int PW = DEPTH_LOG2 + 1;

   logic                         sample;
   logic                         din;
   logic                         timeout;
   logic [3:0]                   bit_cnt;
   logic [PS2_PARITY:PS2_START]  sr;
   logic [DEPTH_LOG2:0]          wr_ptr;
   logic [DEPTH_LOG2:0]          rd_ptr;
   ps2_byte_t                    mem [2**DEPTH_LOG2];
   logic                         frame_done;
   logic                         start_stop_bad;
   logic                         parity_bad;
   logic                         good;
   logic                         empty;
   logic                         full;
   logic                         rd_acc;
   logic                         wr_acc;

   ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
      .clk       (clk),
      .clr       (clr),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .sample    (sample),
      .data_sync (din)
   );

   // sr holds start..parity when the stop bit arrives; din is the stop bit
   assign frame_done     = sample && (bit_cnt == PS2_STOP);
   assign start_stop_bad = sr[PS2_START] | ~din;
   assign parity_bad     = ~(^sr[PS2_PARITY:1]);
   assign good           = frame_done & ~start_stop_bad & ~parity_bad;

   assign empty  = (wr_ptr == rd_ptr);
   assign full   = (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]) &&
                   (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]);
   assign rd_acc = ~rdn & ~empty;
   // a read in the same cycle frees the slot a full FIFO needs
   assign wr_acc = good & (~full | rd_acc);

   assign ready = ~empty;
   assign level = wr_ptr - rd_ptr;
   assign data  = mem[rd_ptr[DEPTH_LOG2-1:0]];

`ifdef PS2_RX_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmr;

   always_ff @(posedge clk) begin
      if (clr) begin
         tmr <= '0;
      end else if (sample) begin
         tmr <= TW'(TIMEOUT_CYCLES - 1);
      end else if ((bit_cnt != 4'd0) && (tmr != '0)) begin
         tmr <= tmr - TW'(1);
      end
   end

   assign timeout = (bit_cnt != 4'd0) && (tmr == '0) && !sample;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES > 0);
   assign timeout        = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (clr) begin
         bit_cnt    <= 4'd0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         overflow   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         if (timeout) begin
            bit_cnt <= 4'd0;
         end else if (sample) begin
            bit_cnt <= (bit_cnt == PS2_STOP) ? 4'd0 : bit_cnt + 4'd1;
         end
         if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
         if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
         overflow   <= (good & full & ~rd_acc) | (overflow & ~rd_acc);
         parity_err <= (frame_done & parity_bad) | (parity_err & ~rd_acc);
         frame_err  <= (frame_done & start_stop_bad) | timeout | (frame_err & ~rd_acc);
      end
   end

   always_ff @(posedge clk) begin
      if (sample) sr <= {din, sr[PS2_PARITY:1]};
      if (wr_acc) mem[wr_ptr[DEPTH_LOG2-1:0]] <= sr[8:1];
   end
endmodule
